imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: fills the CPU's word-addressed instruction store at run time.
//  Takes a byte stream from the UART receiver and assembles it into 32-bit instruction words.
//  Writes each word through a single write port, then releases the CPU from hold.
//  Sits between the UART RX and the instruction RAM, which is read by fetch with a byte address.
// PARAMETERS
//  MEM_WORDS    32       capacity of instruction store in words; larger loads are rejected
//  TIMEOUT_CYC  1000000  max clk cycles between accepted bytes before abort
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-high
//  start      in   1   1-cycle pulse: begin a load session (ignored unless IDLE/DONE/ERR)
//  rx_data    in   8   received byte
//  rx_valid   in   1   1-cycle strobe, rx_data valid
//  mem_we     out  1   1-cycle write strobe to instruction store
//  mem_addr   out  31  byte address of word being written (bits[1:0]=0)
//  mem_wdata  out  32  instruction word
//  cpu_hold   out  1   holds CPU PC/fetch while loading
//  done       out  1   level: last session completed OK
//  error      out  1   level: last session aborted (overflow/timeout/checksum)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Memory contents not touched. Reset mid-session aborts silently (no error).
//  Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words x 4 bytes, MSB first.
//  FSM: IDLE -start-> LEN_HI -byte-> LEN_LO -byte-> DATA | DONE (N=0) | ERR (N>MEM_WORDS);
//   DATA -Nth word written-> DONE; any state except IDLE/DONE/ERR -timeout-> ERR; DONE/ERR -start-> LEN_HI.
//  start: clears done/error; sets cpu_hold the next cycle. start while busy ignored. start together with rx_valid: that byte is dropped.
//  cpu_hold=1 in LEN_HI, LEN_LO, DATA (and CHK); 0 in IDLE, DONE, ERR.
//  Byte assembly: shift register, byte_cnt 0..3. On the 4th byte's rx_valid at edge k:
//   mem_we=1 during cycle k+1 with mem_addr={word_idx,2'b00}, mem_wdata=assembled word.
//  mem_we: exactly one cycle per word. word_idx increments after each write.
//  mem_addr/mem_wdata hold their last values when mem_we=0.
//  Overflow: N>MEM_WORDS -> ERR immediately after LEN_LO. No mem_we is issued.
//  N=MEM_WORDS is legal; last address = (MEM_WORDS-1)*4.
//  Timeout: gap counter resets on each accepted byte. At TIMEOUT_CYC with no byte -> ERR.
//   Words already written stay written; the partial word is discarded.
//  rx_valid in IDLE/DONE/ERR ignored.
//  Final write and DONE: done rises the cycle after the final mem_we, and cpu_hold falls the same cycle.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   Frame gains one trailing byte: XOR of all preceding frame bytes (length bytes included).
//   After the last word the FSM enters CHK; the comparison is made on the checksum byte.
//   Match -> DONE; mismatch -> ERR (words already written). Timeout applies in CHK.
//  Not defined: no CHK state; DATA -> DONE directly; frame carries no checksum byte.
// TESTING
//  1 Load N=3 {ac000010,8c080010,3c09000f} -> mem_we pulses at addr 0,4,8 with those data; done=1; cpu_hold 1->0.
//  2 Frame 00 21 (N=33, MEM_WORDS=32) -> error=1 after LEN_LO; no mem_we; cpu_hold=0.
//  3 N=32, data words i -> 32 writes, last addr 0x7C data 0x1F; done=1.
//  4 N=2, stop after 5 data bytes, wait TIMEOUT_CYC -> 1 write at addr 0; error=1; partial word not written.
//  5 Reset asserted mid-word, then start + N=1 -> single write at addr 0; done=1, error=0.
//  6 (LOADER_CHECKSUM_EN) N=1 word 0000000c, chk 0x0D -> done; chk 0x00 -> error; write issued in both cases.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a UART byte stream into 32-bit words and writes them
// to the instruction store while holding the CPU. Optional: LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_WORDS   = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [30:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    len_hi_q;
    logic [15:0]   len_q;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift_q;
    logic [15:0]   word_idx;
    logic [GW-1:0] gap_q;
    logic          busy;
    logic          start_ok;
    logic          timeout;
    logic          last_word;
    logic [15:0]   len_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
    logic          last_byte;
`endif

    assign busy = (state == S_LEN_HI) || (state == S_LEN_LO) ||
`ifdef LOADER_CHECKSUM_EN
                  (state == S_CHK) ||
`endif
                  (state == S_DATA);
    assign start_ok  = start && !busy;
    assign timeout   = busy && !rx_valid && (gap_q == GW'(TIMEOUT_CYC - 1));
    assign len_n     = {len_hi_q, rx_data};
    assign last_word = (word_idx == (len_q - 16'd1));
`ifdef LOADER_CHECKSUM_EN
    assign last_byte = (state == S_DATA) && rx_valid && (byte_cnt == 2'd3);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; timeout loses to any byte arriving the same cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (rx_valid)     state_nxt = S_LEN_LO;
                else if (timeout) state_nxt = S_ERR;
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (len_n == 16'd0)                 state_nxt = S_DONE;
                    else if (len_n > 16'(MEM_WORDS))   state_nxt = S_ERR;
                    else                                state_nxt = S_DATA;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (last_byte && last_word) state_nxt = S_CHK;
                else if (timeout)           state_nxt = S_ERR;
`else
                if (mem_we && last_word) state_nxt = S_DONE;
                else if (timeout)        state_nxt = S_ERR;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid)
                    state_nxt = (rx_data == csum_q) ? S_DONE : S_ERR;
                else if (timeout)
                    state_nxt = S_ERR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        cpu_hold = busy;
        done     = (state == S_DONE);
        error    = (state == S_ERR);
    end

    // Byte assembly, write strobe, word index and inter-byte gap counter
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_hi_q  <= '0;
            len_q     <= '0;
            byte_cnt  <= '0;
            shift_q   <= '0;
            word_idx  <= '0;
            gap_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we) word_idx <= word_idx + 16'd1;
            if (start_ok) begin
                byte_cnt <= '0;
                word_idx <= '0;
                gap_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end else if (busy) begin
                if (rx_valid)     gap_q <= '0;
                else if (!timeout) gap_q <= gap_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (rx_valid && state != S_CHK) csum_q <= csum_q ^ rx_data;
`endif
                if (rx_valid && state == S_LEN_HI) len_hi_q <= rx_data;
                if (rx_valid && state == S_LEN_LO) len_q <= len_n;
                if (rx_valid && state == S_DATA) begin
                    shift_q  <= {shift_q[15:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {13'd0, word_idx, 2'b00};
                        mem_wdata <= {shift_q, rx_data};
                    end
                end
            end
        end
    end

endmodule
